// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: state encoding,
// frame geometry and the stop-bit index helper.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

    // Bit index of the stop bit: follows the data bits, shifted by one when a parity bit is present.
    function automatic logic [3:0] stop_bit_idx(input logic par_en);
        return par_en ? 4'(DATA_BITS + 2) : 4'(DATA_BITS + 1);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter; the bit counter advances
// each time the edge counter wraps at prescale-1.
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  edge_last
);

    assign edge_last = (edge_cnt == prescale - PRESCALE_W'(1));

    // Clear wins over enable so an aborted or finished frame restarts from zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_en) begin
            if (edge_last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: detects the start edge, walks one frame
// through START/DATA/PARITY/STOP and qualifies the byte in DONE.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output rx_state_e             fsm_state
);

    rx_state_e             state, state_nxt;
    logic [PRESCALE_W-1:0] pre_sh;
    logic                  par_en_sh;
    logic                  cnt_en, cnt_clr, shadow_ld, edge_last;
    logic [PRESCALE_W-1:0] s_pt;

    assign s_pt = (pre_sh >> 1) + PRESCALE_W'(1);

    uart_rx_edge_bit_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .prescale  (pre_sh),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .edge_last (edge_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            pre_sh    <= PRESCALE_W'(8);
            par_en_sh <= 1'b0;
        end else begin
            state <= state_nxt;
            if (shadow_ld) begin
                pre_sh    <= Prescale;
                par_en_sh <= PAR_EN;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shadow_ld = 1'b0;
        cnt_en    = (state == ST_START) || (state == ST_DATA) ||
                    (state == ST_PARITY) || (state == ST_STOP);
        case (state)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_nxt = ST_START;
                    cnt_clr   = 1'b1;
                    shadow_ld = 1'b1;
                end
            end
            ST_START: begin
                if (edge_last) begin
                    if (strt_glitch) begin
                        state_nxt = ST_IDLE;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (edge_last && (bit_cnt == 4'(DATA_BITS)))
                    state_nxt = par_en_sh ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (edge_last)
                    state_nxt = ST_STOP;
            end
            ST_STOP: begin
                // The stop checker registers its result at S, so S+1 is the earliest safe exit.
                if (edge_cnt == s_pt + PRESCALE_W'(1))
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                if (!RX_IN) begin
                    state_nxt = ST_START;
                    shadow_ld = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    assign fsm_state   = state;
    assign dat_samp_en = (state != ST_IDLE);
    assign strt_chk_en = (state == ST_START)  && (edge_cnt == s_pt);
    assign deser_en    = (state == ST_DATA)   && (edge_cnt == s_pt);
    assign par_chk_en  = (state == ST_PARITY) && (edge_cnt == s_pt);
    assign stp_chk_en  = (state == ST_STOP)   && (edge_cnt == s_pt);
    assign data_valid  = (state == ST_DONE) && !stp_err && !(par_en_sh && par_err);

endmodule
